uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver for the UART block; the receive counterpart of the byte-write/`tx_busy` transmit path.
- Oversamples the asynchronous `rx` line, deframes 8N1 frames (1 start, 8 data LSB-first, 1 stop) and presents each byte on `dout` with a level `ready` flag.
- The consumer clears `ready` with a one-cycle `rd_en`.
- Sits beside the transmitter in the UART core and is driven by the transmitter's `tx` line in loopback benches.

Parameters:
- CLK_DIV, 54, clock cycles per oversample tick (min 2).
- OVS, 16, oversample ticks per bit (even, min 4).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, idle high, asynchronous to clk.
- rd_en  input  1  one-cycle read strobe; clears ready/overrun.
- dout  output  8  last correctly framed byte.
- ready  output  1  level; high while dout holds an unread byte.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  sticky; a new byte overwrote an unread byte.
- rx_busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (reset=0, async): state IDLE; dout=8'h00; ready=0; frame_err=0; overrun=0; rx_busy=0; both synchronizer flops =1; tick divider and bit counters =0. A frame in progress is discarded.
- rx passes through a 2-flop synchronizer (rxs). All decisions use rxs; latency from the rx pin is 2 clocks.
- Tick divider: held at 0 in IDLE; otherwise counts 0..CLK_DIV-1 and emits a one-clock tick on wrap. Tick counter counts 0..OVS-1 per bit.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: rxs==0 -> START, counters cleared.
- START: at tick OVS/2, sample rxs (start-bit centre).
  - rxs==1 -> false start; return to IDLE with no outputs changed.
  - rxs==0 -> DATA; bit index = 0.
- DATA: every OVS ticks, sample rxs into shift[bit index], LSB first. After bit 7 -> STOP.
- STOP: OVS ticks after the bit-7 sample, sample rxs.
  - rxs==1 -> on that same clock edge: dout <= shift; ready <= 1; go to IDLE. The next start edge can be detected from the following cycle.
  - rxs==0 -> frame_err pulses for exactly 1 clock; dout, ready and overrun unchanged; go to BREAK.
- BREAK: wait for rxs==1, then go to IDLE. A held-low line produces exactly one frame_err.
- Nominal timing: dout/ready update (CLK_DIV*OVS*9.5)+2 clocks after the falling rx start edge, ±1 clock.
- rd_en while ready=1: ready <= 0 and overrun <= 0 at the next edge.
- rd_en while ready=0: ignored.
- Valid frame completes while ready=1 and rd_en=0: dout overwritten, ready stays 1, overrun <= 1.
- Valid frame completes on the same cycle as rd_en: new byte wins; ready stays 1; overrun <= 0.
- overrun remains high until rd_en or reset.
- frame_err never sets ready or overrun.

Test Plan:
- Parameters CLK_DIV=4, OVS=16 (64 clk/bit); reset released, rx idle high, frame 8'hA5 sent -> ready rises 610±1 clocks after the start edge; dout=8'hA5; frame_err=0; rx_busy high for the whole frame.
- Back-to-back frames 8'h00 then 8'hFF with no idle gap, rd_en pulsed after each ready -> dout 8'h00 then 8'hFF; overrun=0.
- Frames 8'h3C and 8'hC3, no rd_en -> dout=8'hC3; ready=1; overrun=1. Then rd_en -> ready=0 and overrun=0 next cycle.
- Low glitch on rx of 20 clocks -> false start; no ready and no frame_err; rx_busy returns low.
- Frame 8'h55 with stop bit low, then rx held low for 2000 clocks -> single 1-cycle frame_err; ready=0; dout unchanged. After rx returns high, a valid 8'h81 is received correctly.
- reset asserted during data bit 4 of 8'h5A -> all outputs reset immediately. After release, the next valid 8'h12 is received with dout=8'h12.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with oversampled start detection and centre sampling.
// Parameters: CLK_DIV clocks per oversample tick (>=2), OVS ticks per bit (even, >=4).
// Ports:
//   clk       rising-edge system clock
//   reset     asynchronous active-low reset
//   rx        serial input, idle high, asynchronous to clk
//   rd_en     one-cycle read strobe, clears ready and overrun
//   dout      last correctly framed byte
//   ready     high while dout holds an unread byte
//   frame_err one-cycle pulse when the stop bit is sampled low
//   overrun   sticky, set when a new byte replaced an unread one
//   rx_busy   high whenever the receiver is not idle
module uart_rx #(
    parameter int CLK_DIV = 54,
    parameter int OVS     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] dout,
    output logic       ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       rx_busy
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int OW = $clog2(OVS);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t          r_state, w_next;
    logic [1:0]      r_sync;
    logic [DW-1:0]   r_div;
    logic [OW-1:0]   r_ovs;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            w_rxs, w_tick, w_mid, w_end, w_stop_ok;

    assign w_rxs     = r_sync[1];
    // r_div sits at 0 in IDLE, so no tick can fire there
    assign w_tick    = r_div == DW'(CLK_DIV - 1);
    assign w_mid     = w_tick && r_ovs == OW'(OVS / 2 - 1);
    assign w_end     = w_tick && r_ovs == OW'(OVS - 1);
    assign w_stop_ok = r_state == STOP && w_end && w_rxs;
    assign rx_busy   = r_state != IDLE;

    always_ff @(posedge clk or negedge reset)
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    w_next = w_rxs ? IDLE : START;
            START:   w_next = w_mid ? (w_rxs ? IDLE : DATA) : START;
            DATA:    w_next = (w_end && r_bit == 3'd7) ? STOP : DATA;
            STOP:    w_next = w_end ? (w_rxs ? IDLE : BREAK) : STOP;
            BREAK:   w_next = w_rxs ? IDLE : BREAK;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync    <= 2'b11;
            r_div     <= '0;
            r_ovs     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            dout      <= '0;
            ready     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], rx};
            r_div     <= (r_state == IDLE || w_tick) ? '0 : r_div + 1'b1;
            // the start-bit centre realigns the tick phase so every later sample lands mid-bit
            if (r_state == IDLE || (r_state == START && w_mid) || w_end) r_ovs <= '0;
            else if (w_tick)                                             r_ovs <= r_ovs + 1'b1;
            if (r_state != DATA)  r_bit <= '0;
            else if (w_end)       r_bit <= r_bit + 1'b1;
            if (r_state == DATA && w_end) r_shift <= {w_rxs, r_shift[7:1]};
            frame_err <= r_state == STOP && w_end && !w_rxs;
            // a read on the completion cycle consumes the old byte, so no overrun is flagged
            if (w_stop_ok) begin
                dout    <= r_shift;
                ready   <= 1'b1;
                overrun <= !rd_en && ready;
            end else if (rd_en && ready) begin
                ready   <= 1'b0;
                overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx with CLK_DIV=4, OVS=16 (64 clocks per bit).
// Drives framed bytes on rx, pulses rd_en, and checks dout/ready/overrun/frame_err/rx_busy.
module tb_uart_rx;
    logic       clk, reset, rx, rd_en;
    logic [7:0] dout;
    logic       ready, frame_err, overrun, rx_busy;

    int n_cmp = 0, n_err = 0;
    int cyc = 0, start_cyc = 0, rise_cyc = -1, ferr_cnt = 0, busy_gap = 0;
    logic ready_q = 1'b0, mon_busy = 1'b0;

    uart_rx #(.CLK_DIV(4), .OVS(16)) dut (
        .clk(clk), .reset(reset), .rx(rx), .rd_en(rd_en), .dout(dout),
        .ready(ready), .frame_err(frame_err), .overrun(overrun), .rx_busy(rx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ready && !ready_q) rise_cyc = cyc;
        ready_q = ready;
        if (frame_err) ferr_cnt++;
        if (mon_busy && (cyc - start_cyc) >= 3 && (cyc - start_cyc) <= 610 && !rx_busy) busy_gap++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    // Caller must be #1 after a rising edge; frames chain with no idle gap.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        start_cyc = cyc;
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (64) @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_rd();
        @(posedge clk); #1 rd_en = 1'b1;
        @(posedge clk); #1 rd_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0; rx = 1'b1; rd_en = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h want 00", dout); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", rx_busy); end
        @(posedge clk); #1 reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int lat;
        rise_cyc = -1; ferr_cnt = 0; busy_gap = 0; mon_busy = 1'b1;
        send_frame(8'hA5, 1'b1);
        mon_busy = 1'b0;
        lat = rise_cyc - start_cyc;
        n_cmp++; if (rise_cyc < 0 || lat < 609 || lat > 611) begin n_err++; $display("FAIL basic_latency: got %0d want 610+-1", lat); end
        n_cmp++; if (dout !== 8'hA5) begin n_err++; $display("FAIL basic_dout: got %h want a5", dout); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", ready); end
        n_cmp++; if (ferr_cnt !== 0) begin n_err++; $display("FAIL basic_ferr: got %0d pulses want 0", ferr_cnt); end
        n_cmp++; if (busy_gap !== 0) begin n_err++; $display("FAIL basic_busy_gap: got %0d idle cycles want 0", busy_gap); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL basic_busy_end: got %b want 0", rx_busy); end
        pulse_rd();
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL basic_read_clr: got %b want 0", ready); end
        #1;
    endtask

    task automatic test_back_to_back();
        ferr_cnt = 0;
        @(posedge clk); #1;
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                for (int i = 0; i < 2000 && !ready; i++) @(negedge clk);
                n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready0: got %b want 1", ready); end
                n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL b2b_dout0: got %h want 00", dout); end
                pulse_rd();
                for (int i = 0; i < 2000 && !ready; i++) @(negedge clk);
                n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready1: got %b want 1", ready); end
                n_cmp++; if (dout !== 8'hFF) begin n_err++; $display("FAIL b2b_dout1: got %h want ff", dout); end
                n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
                pulse_rd();
            end
        join
        n_cmp++; if (ferr_cnt !== 0) begin n_err++; $display("FAIL b2b_ferr: got %0d pulses want 0", ferr_cnt); end
    endtask

    task automatic test_overrun();
        send_frame(8'h3C, 1'b1);
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_first: got %b want 0", overrun); end
        send_frame(8'hC3, 1'b1);
        n_cmp++; if (dout !== 8'hC3) begin n_err++; $display("FAIL ovr_dout: got %h want c3", dout); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL ovr_ready: got %b want 1", ready); end
        n_cmp++; if (overrun !== 1'b1) begin n_err++; $display("FAIL ovr_set: got %b want 1", overrun); end
        pulse_rd();
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL ovr_rd_ready: got %b want 0", ready); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ovr_rd_clr: got %b want 0", overrun); end
        #1;
    endtask

    task automatic test_false_start();
        ferr_cnt = 0;
        @(posedge clk); #1 rx = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_on: got %b want 1", rx_busy); end
        repeat (10) @(posedge clk);
        #1 rx = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL glitch_ready: got %b want 0", ready); end
        n_cmp++; if (ferr_cnt !== 0) begin n_err++; $display("FAIL glitch_ferr: got %0d pulses want 0", ferr_cnt); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_off: got %b want 0", rx_busy); end
        n_cmp++; if (dout !== 8'hC3) begin n_err++; $display("FAIL glitch_dout: got %h want c3", dout); end
        @(posedge clk); #1;
    endtask

    task automatic test_frame_err();
        ferr_cnt = 0;
        send_frame(8'h55, 1'b0);
        repeat (2000) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (ferr_cnt !== 1) begin n_err++; $display("FAIL ferr_count: got %0d pulses want 1", ferr_cnt); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL ferr_ready: got %b want 0", ready); end
        n_cmp++; if (dout !== 8'hC3) begin n_err++; $display("FAIL ferr_dout: got %h want c3", dout); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL ferr_overrun: got %b want 0", overrun); end
        n_cmp++; if (rx_busy !== 1'b1) begin n_err++; $display("FAIL ferr_break_busy: got %b want 1", rx_busy); end
        @(posedge clk); #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        send_frame(8'h81, 1'b1);
        @(negedge clk);
        n_cmp++; if (dout !== 8'h81) begin n_err++; $display("FAIL ferr_next_dout: got %h want 81", dout); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL ferr_next_ready: got %b want 1", ready); end
        n_cmp++; if (ferr_cnt !== 1) begin n_err++; $display("FAIL ferr_next_count: got %0d pulses want 1", ferr_cnt); end
        pulse_rd();
        #1;
    endtask

    task automatic test_reset_mid();
        logic [9:0] f;
        f = {1'b1, 8'h5A, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            rx = f[i];
            repeat (64) @(posedge clk);
            #1;
        end
        rx = f[5];
        repeat (32) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL rstmid_dout: got %h want 00", dout); end
        n_cmp++; if (ready !== 1'b0) begin n_err++; $display("FAIL rstmid_ready: got %b want 0", ready); end
        n_cmp++; if (overrun !== 1'b0) begin n_err++; $display("FAIL rstmid_overrun: got %b want 0", overrun); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL rstmid_ferr: got %b want 0", frame_err); end
        n_cmp++; if (rx_busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b want 0", rx_busy); end
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        send_frame(8'h12, 1'b1);
        @(negedge clk);
        n_cmp++; if (dout !== 8'h12) begin n_err++; $display("FAIL rstmid_next_dout: got %h want 12", dout); end
        n_cmp++; if (ready !== 1'b1) begin n_err++; $display("FAIL rstmid_next_ready: got %b want 1", ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_false_start();
        test_frame_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
